// File: rtl/tlb_emul_arb_pkg.sv
// Shared types and constants for the tlb_emul_arb translation-port arbiter.
package tlb_emul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int DefaultTimeoutCycles = 256;

endpackage

// File: rtl/tlb_emul_arb_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set request bit
// at or after ptr_i, wrapping modulo NumPorts.
module rr_pick #(
    parameter int NumPorts = 2,
    parameter int PtrW     = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [PtrW-1:0]     ptr_i,
    output logic                gnt_valid_o,
    output logic [PtrW-1:0]     gnt_idx_o
);

    logic [PtrW:0]   w_sum [NumPorts];
    logic [PtrW-1:0] w_idx [NumPorts];

    // w_idx[gi] is the port that sits gi positions after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NumPorts; gi++) begin : g_rot
            assign w_sum[gi] = {1'b0, ptr_i} + (PtrW+1)'(gi);
            assign w_idx[gi] = (w_sum[gi] >= (PtrW+1)'(NumPorts))
                             ? PtrW'(w_sum[gi] - (PtrW+1)'(NumPorts))
                             : w_sum[gi][PtrW-1:0];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (req_i[w_idx[i]]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = w_idx[i];
            end
        end
    end

endmodule

// File: rtl/tlb_emul_arb.sv
// Round-robin arbiter sharing one translation port between NumPorts requesters.
// Optional BUSY watchdog enabled by defining TLB_EMUL_ARB_TIMEOUT_EN.
module tlb_emul_arb
    import tlb_emul_arb_pkg::*;
#(
    parameter int NumPorts   = 2,
    parameter int VAddrWidth = 64,
    parameter int PAddrWidth = 64
`ifdef TLB_EMUL_ARB_TIMEOUT_EN
    , parameter int TimeoutCycles = DefaultTimeoutCycles
`endif
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [NumPorts-1:0]                  req_i,
    input  logic [NumPorts-1:0][VAddrWidth-1:0]  req_vaddr_i,
    output logic [NumPorts-1:0]                  rsp_valid_o,
    output logic [PAddrWidth-1:0]                rsp_paddr_o,
    output logic                                 rsp_ex_o,
    output logic                                 tlb_req_o,
    output logic [VAddrWidth-1:0]                tlb_vaddr_o,
    input  logic                                 tlb_valid_i,
    input  logic [PAddrWidth-1:0]                tlb_paddr_i,
    input  logic                                 tlb_ex_i
`ifdef TLB_EMUL_ARB_TIMEOUT_EN
    , output logic                               timeout_o
`endif
);

    localparam int PtrW = $clog2(NumPorts);

    arb_state_e              r_state;
    arb_state_e              w_state_next;
    logic [PtrW-1:0]         r_ptr;
    logic [PtrW-1:0]         r_gnt;
    logic [VAddrWidth-1:0]   r_vaddr;
    logic [PAddrWidth-1:0]   r_paddr;
    logic                    r_ex;
    logic                    r_tlb_req;

    logic                    w_pick_valid;
    logic [PtrW-1:0]         w_pick_idx;
    logic                    w_wrap_valid;
    logic [PtrW-1:0]         w_wrap_idx;
    logic [PtrW-1:0]         w_ptr_next;
    logic [NumPorts-1:0]     w_gnt_onehot;
    logic                    w_grant;
    logic                    w_to_fire;

    assign w_gnt_onehot = {{(NumPorts-1){1'b0}}, 1'b1} << r_gnt;
    assign w_grant      = (r_state == IDLE) && w_pick_valid && !flush_i;

    rr_pick #(.NumPorts(NumPorts)) u_pick (
        .req_i       (req_i),
        .ptr_i       (r_ptr),
        .gnt_valid_o (w_pick_valid),
        .gnt_idx_o   (w_pick_idx)
    );

    // Masking out the owner and searching from it yields (gnt+1) mod NumPorts.
    rr_pick #(.NumPorts(NumPorts)) u_wrap (
        .req_i       (~w_gnt_onehot),
        .ptr_i       (r_gnt),
        .gnt_valid_o (w_wrap_valid),
        .gnt_idx_o   (w_wrap_idx)
    );

    assign w_ptr_next = w_wrap_valid ? w_wrap_idx : '0;

`ifdef TLB_EMUL_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] r_cnt;
    logic            r_timeout;

    // Fires on the BUSY cycle in which the count would reach TimeoutCycles.
    assign w_to_fire = (r_state == BUSY) && !flush_i && !tlb_valid_i &&
                       (r_cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire;
            if (r_state != BUSY)
                r_cnt <= '0;
            else if (!tlb_valid_i)
                r_cnt <= r_cnt + CntW'(1);
        end
    end
`else
    assign w_to_fire = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_grant) w_state_next = BUSY;
            BUSY: begin
                if (flush_i)
                    w_state_next = IDLE;
                else if (tlb_valid_i || w_to_fire)
                    w_state_next = RESP;
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_vaddr   <= '0;
            r_paddr   <= '0;
            r_ex      <= 1'b0;
            r_tlb_req <= 1'b0;
        end else begin
            r_tlb_req <= (w_state_next == BUSY);
            if (w_grant) begin
                r_gnt   <= w_pick_idx;
                r_vaddr <= req_vaddr_i[w_pick_idx];
            end
            if ((r_state == BUSY && flush_i) || r_state == RESP)
                r_ptr <= w_ptr_next;
            if (r_state == BUSY && !flush_i && tlb_valid_i) begin
                r_paddr <= tlb_paddr_i;
                r_ex    <= tlb_ex_i;
            end else if (w_to_fire) begin
                r_paddr <= '0;
                r_ex    <= 1'b1;
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_paddr_o = '0;
        rsp_ex_o    = 1'b0;
`ifdef TLB_EMUL_ARB_TIMEOUT_EN
        timeout_o   = 1'b0;
`endif
        if (r_state == RESP) begin
            rsp_valid_o = w_gnt_onehot;
            rsp_paddr_o = r_paddr;
            rsp_ex_o    = r_ex;
`ifdef TLB_EMUL_ARB_TIMEOUT_EN
            timeout_o   = r_timeout;
`endif
        end
    end

    assign tlb_req_o   = r_tlb_req;
    assign tlb_vaddr_o = r_vaddr;

endmodule

// File: tb/tb_tlb_emul_arb.sv
// Testbench for tlb_emul_arb: vector table, directed corner sequences and a
// randomized run checked against a transaction-level round-robin model.
module tb_tlb_emul_arb;

    localparam int NP = 2;
`ifdef TLB_EMUL_ARB_TIMEOUT_EN
    localparam int STALL = 6;
`else
    localparam int STALL = 20;
`endif

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic [NP-1:0]          req_i;
    logic [NP-1:0][63:0]    req_vaddr_i;
    logic [NP-1:0]          rsp_valid_o;
    logic [63:0]            rsp_paddr_o;
    logic                   rsp_ex_o;
    logic                   tlb_req_o;
    logic [63:0]            tlb_vaddr_o;
    logic                   tlb_valid_i;
    logic [63:0]            tlb_paddr_i;
    logic                   tlb_ex_i;
`ifdef TLB_EMUL_ARB_TIMEOUT_EN
    logic                   timeout_o;
`endif

    logic [63:0] va [NP];
    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int p = 0; p < NP; p++) req_vaddr_i[p] = va[p];
    end

    tlb_emul_arb #(
        .NumPorts   (NP),
        .VAddrWidth (64),
        .PAddrWidth (64)
`ifdef TLB_EMUL_ARB_TIMEOUT_EN
        , .TimeoutCycles (8)
`endif
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_i       (req_i),
        .req_vaddr_i (req_vaddr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_paddr_o (rsp_paddr_o),
        .rsp_ex_o    (rsp_ex_o),
        .tlb_req_o   (tlb_req_o),
        .tlb_vaddr_o (tlb_vaddr_o),
        .tlb_valid_i (tlb_valid_i),
        .tlb_paddr_i (tlb_paddr_i),
        .tlb_ex_i    (tlb_ex_i)
`ifdef TLB_EMUL_ARB_TIMEOUT_EN
        , .timeout_o (timeout_o)
`endif
    );

    typedef struct {
        logic [NP-1:0] req;
        int            lat;
        logic [63:0]   vbase;
        logic [63:0]   pa;
        bit            ex;
        int            exp_port;
    } vec_t;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_vaddrs(input logic [63:0] base);
        for (int p = 0; p < NP; p++) va[p] = base + 64'(p) * 64'h100;
    endtask

    // Called in the IDLE cycle where req_i has just been raised; returns in RESP.
    task automatic serve(input int port, input int lat, input logic [63:0] pa, input bit ex);
        step();
        chk("tlb_req_rise", {63'b0, tlb_req_o}, 64'd1);
        chk("tlb_vaddr", tlb_vaddr_o, va[port]);
        for (int i = 0; i < lat; i++) begin
            step();
            chk("tlb_req_hold", {63'b0, tlb_req_o}, 64'd1);
            chk("rsp_quiet", {62'b0, rsp_valid_o}, 64'd0);
        end
        tlb_valid_i = 1'b1;
        tlb_paddr_i = pa;
        tlb_ex_i    = ex;
        step();
        tlb_valid_i = 1'b0;
        tlb_ex_i    = 1'b0;
        chk("rsp_valid", {62'b0, rsp_valid_o}, 64'd1 << port);
        chk("rsp_paddr", rsp_paddr_o, pa);
        chk("rsp_ex", {63'b0, rsp_ex_o}, {63'b0, ex});
        chk("tlb_req_fall", {63'b0, tlb_req_o}, 64'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        int m_ptr;
        int g;
        logic [NP-1:0] mask;
        int lat;
        logic [63:0] pa;
        bit ex;

        vecs[0] = '{req: 2'b01, lat: 1, vbase: 64'h1000, pa: 64'h81000, ex: 1'b0, exp_port: 0};
        vecs[1] = '{req: 2'b01, lat: 0, vbase: 64'h2000, pa: 64'h82000, ex: 1'b1, exp_port: 0};
        vecs[2] = '{req: 2'b10, lat: 2, vbase: 64'h3000, pa: 64'h93000, ex: 1'b0, exp_port: 1};
        vecs[3] = '{req: 2'b11, lat: 0, vbase: 64'h4000, pa: 64'hA4000, ex: 1'b0, exp_port: 0};
        vecs[4] = '{req: 2'b11, lat: 3, vbase: 64'h5000, pa: 64'hB5000, ex: 1'b1, exp_port: 1};

        rst_i = 1'b1; flush_i = 1'b0; req_i = '0; tlb_valid_i = 1'b0;
        tlb_paddr_i = '0; tlb_ex_i = 1'b0;
        set_vaddrs(64'h0);
        step();
        step();
        chk("reset_tlb_req", {63'b0, tlb_req_o}, 64'd0);
        chk("reset_tlb_vaddr", tlb_vaddr_o, 64'd0);
        chk("reset_rsp_valid", {62'b0, rsp_valid_o}, 64'd0);
        chk("reset_rsp_paddr", rsp_paddr_o, 64'd0);
        rst_i = 1'b0;

        // Table vectors (pointer starts at 0).
        for (int v = 0; v < 5; v++) begin
            set_vaddrs(vecs[v].vbase);
            req_i = vecs[v].req;
            serve(vecs[v].exp_port, vecs[v].lat, vecs[v].pa, vecs[v].ex);
            req_i = '0;
            step();
            chk("rsp_single_pulse", {62'b0, rsp_valid_o}, 64'd0);
        end

        // Pointer is 0: port-0 transaction moves it to 1, then reset mid-BUSY.
        set_vaddrs(64'h6000);
        req_i = 2'b01;
        serve(0, 0, 64'h1, 1'b0);
        req_i = '0;
        step();
        req_i = 2'b11;
        step();
        chk("pre_reset_grant", tlb_vaddr_o, va[1]);
        step();
        rst_i = 1'b1;
        #1;
        chk("async_rst_tlb_req", {63'b0, tlb_req_o}, 64'd0);
        chk("async_rst_tlb_vaddr", tlb_vaddr_o, 64'd0);
        chk("async_rst_rsp", {62'b0, rsp_valid_o}, 64'd0);
        chk("async_rst_paddr", rsp_paddr_o, 64'd0);
        req_i = '0;
        step();
        rst_i = 1'b0;
        step();
        chk("post_reset_no_rsp", {62'b0, rsp_valid_o}, 64'd0);

        // Both ports requesting continuously: grants 0,1,0,1.
        set_vaddrs(64'h7000);
        req_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            serve(t % NP, t, 64'hC000 + 64'(t), 1'b0);
            req_i[t % NP] = 1'b0;
            step();
            req_i[t % NP] = 1'b1;
        end
        req_i = '0;
        step();

        // Flush in the 3rd BUSY cycle; pointer at 0, so port 0 is granted.
        do_reset();
        set_vaddrs(64'h8000);
        req_i = 2'b11;
        step();
        chk("flush_grant", tlb_vaddr_o, va[0]);
        step();
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        req_i = '0;
        chk("flush_no_rsp", {62'b0, rsp_valid_o}, 64'd0);
        chk("flush_tlb_req", {63'b0, tlb_req_o}, 64'd0);
        tlb_valid_i = 1'b1;
        tlb_paddr_i = 64'hDEAD;
        step();
        tlb_valid_i = 1'b0;
        chk("late_valid_ignored", {62'b0, rsp_valid_o}, 64'd0);
        step();
        chk("late_valid_ignored2", {62'b0, rsp_valid_o}, 64'd0);
        req_i = 2'b11;
        serve(1, 1, 64'hE000, 1'b0);
        req_i = '0;
        step();

        // Stalled translation; requester drops req at cycle 5.
        set_vaddrs(64'h9000);
        req_i = 2'b01;
        step();
        for (int c = 1; c <= STALL; c++) begin
            if (c == 5) req_i[0] = 1'b0;
            chk("stall_tlb_req", {63'b0, tlb_req_o}, 64'd1);
            chk("stall_no_rsp", {62'b0, rsp_valid_o}, 64'd0);
            if (c < STALL) step();
        end
        tlb_valid_i = 1'b1;
        tlb_paddr_i = 64'h99000;
        step();
        tlb_valid_i = 1'b0;
        chk("stall_rsp", {62'b0, rsp_valid_o}, 64'd1);
        chk("stall_paddr", rsp_paddr_o, 64'h99000);
        step();
        chk("stall_one_pulse", {62'b0, rsp_valid_o}, 64'd0);

`ifdef TLB_EMUL_ARB_TIMEOUT_EN
        do_reset();
        set_vaddrs(64'hA000);
        req_i = 2'b01;
        step();
        for (int c = 1; c < 8; c++) begin
            step();
            chk("to_busy", {63'b0, tlb_req_o}, 64'd1);
            chk("to_no_pulse", {63'b0, timeout_o}, 64'd0);
        end
        step();
        chk("to_rsp_valid", {62'b0, rsp_valid_o}, 64'd1);
        chk("to_rsp_ex", {63'b0, rsp_ex_o}, 64'd1);
        chk("to_rsp_paddr", rsp_paddr_o, 64'd0);
        chk("to_pulse", {63'b0, timeout_o}, 64'd1);
        req_i = '0;
        step();
        chk("to_pulse_end", {63'b0, timeout_o}, 64'd0);
`endif

        // Randomized transactions against a transaction-level model.
        do_reset();
        m_ptr = 0;
        for (int t = 0; t < 80; t++) begin
            mask = NP'($urandom_range(0, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) va[p] = {$urandom, $urandom};
            req_i = mask;
            if (mask == '0) begin
                step();
                chk("rand_idle", {63'b0, tlb_req_o}, 64'd0);
                continue;
            end
            if ($urandom_range(0, 5) == 0) begin
                flush_i = 1'b1;
                step();
                flush_i = 1'b0;
                chk("rand_idle_flush", {63'b0, tlb_req_o}, 64'd0);
            end
            g = -1;
            for (int k = 0; k < NP; k++)
                if (g < 0 && mask[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
            lat = $urandom_range(0, 4);
            pa  = {$urandom, $urandom};
            ex  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                step();
                chk("rand_vaddr", tlb_vaddr_o, va[g]);
                for (int i = 0; i < lat; i++) step();
                flush_i     = 1'b1;
                tlb_valid_i = 1'($urandom_range(0, 1));
                step();
                flush_i     = 1'b0;
                tlb_valid_i = 1'b0;
                req_i = '0;
                chk("rand_flush_no_rsp", {62'b0, rsp_valid_o}, 64'd0);
                chk("rand_flush_tlb_req", {63'b0, tlb_req_o}, 64'd0);
            end else begin
                serve(g, lat, pa, ex);
                req_i = '0;
                step();
            end
            m_ptr = (g + 1) % NP;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
